// File: rtl/vit_bridge_pkg.sv
// Shared constants and types for the debug-host to Viterbi bridge.
package vit_bridge_pkg;

    localparam int unsigned DEF_SOFT_W  = 8;
    localparam int unsigned DEF_STATE_W = 6;

    typedef logic signed [DEF_SOFT_W-1:0] soft_t;

    typedef enum logic {
        FILL = 1'b0,
        HELD = 1'b1
    } pack_state_e;

endpackage

// File: rtl/vit_sym_fifo.sv
// Synchronous first-word-fall-through FIFO for soft symbols.
module vit_sym_fifo
    import vit_bridge_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned W     = DEF_SOFT_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 wdata,
    output logic [W-1:0]                 rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [LW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == LW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
    assign do_push = push & (~full | do_pop);
    assign level   = count;
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + LW'(do_push) - LW'(do_pop);
        end
    end

    // Storage array, no reset needed since reads are gated by empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/vit_dbg_bridge.sv
// Debug-host to Viterbi bridge: strobe-fed symbol FIFO, decoder feed and
// decoded-bit word packer with hold/ack semantics.
// Optional statistics counters are built when VIT_BRIDGE_STATS_EN is defined.
module vit_dbg_bridge
    import vit_bridge_pkg::*;
#(
    parameter int unsigned SOFT_W  = DEF_SOFT_W,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned STATE_W = DEF_STATE_W,
    parameter int unsigned OUT_W   = 16
) (
    input  logic                         clk,
    input  logic                         sys_rst,
    input  logic [SOFT_W-1:0]            host_soft,
    input  logic                         host_strobe,
    input  logic                         host_flush,
    input  logic                         host_ack,
    output logic [SOFT_W-1:0]            vit_soft,
    output logic                         vit_valid,
    input  logic                         vit_ready,
    input  logic                         vit_bit,
    input  logic                         vit_bit_valid,
    input  logic [STATE_W-1:0]           vit_last_state,
    output logic [OUT_W-1:0]             out_word,
    output logic [$clog2(OUT_W+1)-1:0]   out_count,
    output logic [STATE_W-1:0]           out_last_state,
    output logic                         out_valid,
    output logic [$clog2(DEPTH+1)-1:0]   in_level,
    output logic                         in_overflow,
    output logic                         out_overrun,
    output logic [31:0]                  sym_count,
    output logic [31:0]                  bit_count
);

    localparam int unsigned CW = $clog2(OUT_W + 1);

    logic              strobe_prev;
    logic              flush_prev;
    logic              ack_prev;
    logic              push_q;
    logic              flush_q;
    logic              ack_q;
    logic [SOFT_W-1:0] soft_q;

    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              push_take;

    pack_state_e       state;
    pack_state_e       state_nxt;
    logic [OUT_W-1:0]  acc;
    logic [CW-1:0]     cnt;
    logic [OUT_W-1:0]  acc_pk;
    logic [CW-1:0]     cnt_pk;
    logic              word_done;
    logic [OUT_W-1:0]  acc_d;
    logic [CW-1:0]     cnt_d;
    logic [OUT_W-1:0]  word_d;
    logic [CW-1:0]     count_d;
    logic [STATE_W-1:0] last_d;
    logic              valid_d;
    logic              overrun_d;
    logic              load;

    // Previous-level samples for edge detection, updated even during reset.
    always_ff @(posedge clk) begin
        strobe_prev <= host_strobe;
        flush_prev  <= host_flush;
        ack_prev    <= host_ack;
    end

    // Registered rising-edge pulses and the symbol captured with the strobe.
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            push_q  <= 1'b0;
            flush_q <= 1'b0;
            ack_q   <= 1'b0;
            soft_q  <= '0;
        end else begin
            push_q  <= host_strobe & ~strobe_prev;
            flush_q <= host_flush & ~flush_prev;
            ack_q   <= host_ack & ~ack_prev;
            soft_q  <= host_soft;
        end
    end

    assign vit_valid = ~fifo_empty;
    assign pop       = vit_valid & vit_ready;
    assign push_take = push_q & (~fifo_full | pop);

    vit_sym_fifo #(
        .DEPTH (DEPTH),
        .W     (SOFT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (sys_rst),
        .push  (push_q),
        .pop   (pop),
        .wdata (soft_q),
        .rdata (vit_soft),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (in_level)
    );

    // Sticky overflow: a push against a full FIFO with nothing leaving.
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            in_overflow <= 1'b0;
        end else if (push_q & fifo_full & ~pop) begin
            in_overflow <= 1'b1;
        end
    end

    // Pack the incoming bit first, then decide whether a word completes.
    always_comb begin
        acc_pk = acc;
        cnt_pk = cnt;
        if (vit_bit_valid) begin
            for (int i = 0; i < int'(OUT_W); i++) begin
                if (cnt == CW'(i)) acc_pk[i] = vit_bit;
            end
            cnt_pk = cnt + CW'(1);
        end
        word_done = (cnt_pk == CW'(OUT_W)) | (flush_q & (cnt_pk != '0));
    end

    // Packer state register.
    always_ff @(posedge clk) begin
        if (sys_rst) state <= FILL;
        else         state <= state_nxt;
    end

    // Packer next-state: an ack racing a completion keeps the block in HELD.
    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (word_done) state_nxt = HELD;
            HELD:    if (ack_q & ~word_done) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    // Packer outputs: the held word is only replaced when an ack frees it.
    always_comb begin
        acc_d     = acc_pk;
        cnt_d     = cnt_pk;
        word_d    = out_word;
        count_d   = out_count;
        last_d    = out_last_state;
        valid_d   = out_valid;
        overrun_d = out_overrun;
        load      = 1'b0;
        case (state)
            FILL: load = word_done;
            HELD: begin
                load = word_done & ack_q;
                if (ack_q & ~word_done) valid_d = 1'b0;
                if (word_done & ~ack_q) overrun_d = 1'b1;
            end
            default: load = 1'b0;
        endcase
        if (word_done) begin
            acc_d = '0;
            cnt_d = '0;
        end
        if (load) begin
            word_d  = acc_pk;
            count_d = cnt_pk;
            last_d  = vit_last_state;
            valid_d = 1'b1;
        end
    end

    // Packer datapath and held-result registers.
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            acc            <= '0;
            cnt            <= '0;
            out_word       <= '0;
            out_count      <= '0;
            out_last_state <= '0;
            out_valid      <= 1'b0;
            out_overrun    <= 1'b0;
        end else begin
            acc            <= acc_d;
            cnt            <= cnt_d;
            out_word       <= word_d;
            out_count      <= count_d;
            out_last_state <= last_d;
            out_valid      <= valid_d;
            out_overrun    <= overrun_d;
        end
    end

`ifdef VIT_BRIDGE_STATS_EN
    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            sym_count <= '0;
            bit_count <= '0;
        end else begin
            if (push_take && (sym_count != '1))     sym_count <= sym_count + 32'd1;
            if (vit_bit_valid && (bit_count != '1)) bit_count <= bit_count + 32'd1;
        end
    end
`else
    assign sym_count = '0;
    assign bit_count = '0;
`endif

endmodule

// File: tb/tb_vit_dbg_bridge.sv
// Directed bench for vit_dbg_bridge: table-driven packer vectors plus
// hand-written FIFO, overflow, overrun and race sequences.
module tb_vit_dbg_bridge;

    logic        clk = 1'b0;
    logic        sys_rst;
    logic [7:0]  host_soft;
    logic        host_strobe;
    logic        host_flush;
    logic        host_ack;
    logic [7:0]  vit_soft;
    logic        vit_valid;
    logic        vit_ready;
    logic        vit_bit;
    logic        vit_bit_valid;
    logic [5:0]  vit_last_state;
    logic [15:0] out_word;
    logic [4:0]  out_count;
    logic [5:0]  out_last_state;
    logic        out_valid;
    logic [4:0]  in_level;
    logic        in_overflow;
    logic        out_overrun;
    logic [31:0] sym_count;
    logic [31:0] bit_count;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [15:0] pattern;
        int          nbits;
        bit          flush;
        logic [15:0] word;
        logic [4:0]  count;
    } pk_vec_t;

    pk_vec_t vecs [6];

    always #5 clk = ~clk;

    vit_dbg_bridge dut (
        .clk            (clk),
        .sys_rst        (sys_rst),
        .host_soft      (host_soft),
        .host_strobe    (host_strobe),
        .host_flush     (host_flush),
        .host_ack       (host_ack),
        .vit_soft       (vit_soft),
        .vit_valid      (vit_valid),
        .vit_ready      (vit_ready),
        .vit_bit        (vit_bit),
        .vit_bit_valid  (vit_bit_valid),
        .vit_last_state (vit_last_state),
        .out_word       (out_word),
        .out_count      (out_count),
        .out_last_state (out_last_state),
        .out_valid      (out_valid),
        .in_level       (in_level),
        .in_overflow    (in_overflow),
        .out_overrun    (out_overrun),
        .sym_count      (sym_count),
        .bit_count      (bit_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        tick();
        tick();
        sys_rst = 1'b0;
        tick();
    endtask

    task automatic push_sym(input logic [7:0] v);
        host_soft   = v;
        host_strobe = 1'b1;
        tick();
        host_strobe = 1'b0;
        tick();
    endtask

    task automatic send_bits(input logic [15:0] pat, input int n);
        for (int i = 0; i < n; i++) begin
            vit_bit       = pat[i];
            vit_bit_valid = 1'b1;
            tick();
        end
        vit_bit_valid = 1'b0;
        vit_bit       = 1'b0;
    endtask

    task automatic pulse_ack();
        host_ack = 1'b1;
        tick();
        host_ack = 1'b0;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'hA5C3, 16, 1'b0, 16'hA5C3, 5'd16};
        vecs[1] = '{16'h001F,  5, 1'b1, 16'h001F, 5'd5};
        vecs[2] = '{16'hFFFF,  1, 1'b1, 16'h0001, 5'd1};
        vecs[3] = '{16'h7FFF, 15, 1'b1, 16'h7FFF, 5'd15};
        vecs[4] = '{16'h0000, 16, 1'b0, 16'h0000, 5'd16};
        vecs[5] = '{16'hFFF5,  3, 1'b1, 16'h0005, 5'd3};

        host_soft      = 8'h00;
        host_strobe    = 1'b1;
        host_flush     = 1'b0;
        host_ack       = 1'b0;
        vit_ready      = 1'b0;
        vit_bit        = 1'b0;
        vit_bit_valid  = 1'b0;
        vit_last_state = 6'h2A;

        // Strobe held high through reset is not an edge.
        sys_rst = 1'b1;
        repeat (3) tick();
        sys_rst = 1'b0;
        repeat (3) tick();
        chk("rst_in_level", in_level, 0);
        chk("rst_vit_valid", vit_valid, 0);
        chk("rst_vit_soft", vit_soft, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_word", out_word, 0);
        chk("rst_flags", {in_overflow, out_overrun}, 0);
        chk("rst_stats", sym_count | bit_count, 0);
        host_strobe = 1'b0;
        tick();
        chk("rst_no_push", in_level, 0);

        // FIFO latency and ordering.
        host_soft   = 8'hFB;
        host_strobe = 1'b1;
        tick();
        chk("push_t1_valid", vit_valid, 0);
        host_strobe = 1'b0;
        tick();
        chk("push_t2_valid", vit_valid, 1);
        chk("push_t2_level", in_level, 1);
        chk("push_t2_head", vit_soft, 8'hFB);
        push_sym(8'h00);
        push_sym(8'h7F);
        chk("fifo3_level", in_level, 3);
        vit_ready = 1'b1;
        chk("pop_head0", vit_soft, 8'hFB);
        tick();
        chk("pop_head1", vit_soft, 8'h00);
        tick();
        chk("pop_head2", vit_soft, 8'h7F);
        tick();
        chk("pop_empty_valid", vit_valid, 0);
        chk("pop_empty_level", in_level, 0);
        vit_ready = 1'b0;

        // Overflow: 17 pushes into 16 slots.
        for (int i = 1; i <= 17; i++) push_sym(8'(i * 3));
        chk("ovf_level", in_level, 16);
        chk("ovf_flag", in_overflow, 1);
        vit_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("ovf_data%0d", i), vit_soft, 8'(i * 3));
            tick();
        end
        chk("ovf_drained", vit_valid, 0);
        vit_ready = 1'b0;

        // Push coinciding with a pop at full is accepted.
        do_reset();
        for (int i = 0; i < 16; i++) push_sym(8'(100 + i));
        chk("full_level", in_level, 16);
        host_soft   = 8'h55;
        host_strobe = 1'b1;
        tick();
        vit_ready   = 1'b1;
        host_strobe = 1'b0;
        tick();
        vit_ready = 1'b0;
        chk("pushpop_level", in_level, 16);
        chk("pushpop_no_ovf", in_overflow, 0);
        chk("pushpop_head", vit_soft, 8'd101);
        vit_ready = 1'b1;
        repeat (15) tick();
        chk("pushpop_tail", vit_soft, 8'h55);
        tick();
        chk("pushpop_drained", vit_valid, 0);
        vit_ready = 1'b0;

        // Full word, timing, then overrun while held.
        do_reset();
        send_bits(16'h5555, 15);
        chk("word_t0_valid", out_valid, 0);
        vit_bit       = 1'b0;
        vit_bit_valid = 1'b1;
        tick();
        vit_bit_valid = 1'b0;
        chk("word_valid", out_valid, 1);
        chk("word_data", out_word, 16'h5555);
        chk("word_count", out_count, 16);
        chk("word_state", out_last_state, 6'h2A);
        send_bits(16'hFFFF, 16);
        chk("overrun_flag", out_overrun, 1);
        chk("overrun_keep", out_word, 16'h5555);
        chk("overrun_valid", out_valid, 1);
        host_ack = 1'b1;
        tick();
        host_ack = 1'b0;
        chk("ack_t1_valid", out_valid, 1);
        tick();
        chk("ack_t2_valid", out_valid, 0);

        // Table of packer vectors.
        do_reset();
        foreach (vecs[k]) begin
            send_bits(vecs[k].pattern, vecs[k].nbits);
            if (vecs[k].flush) begin
                host_flush = 1'b1;
                tick();
                host_flush = 1'b0;
                chk($sformatf("vec%0d_flush_t1", k), out_valid, 0);
                tick();
            end
            chk($sformatf("vec%0d_valid", k), out_valid, 1);
            chk($sformatf("vec%0d_word", k), out_word, vecs[k].word);
            chk($sformatf("vec%0d_count", k), out_count, vecs[k].count);
            pulse_ack();
            chk($sformatf("vec%0d_acked", k), out_valid, 0);
        end
        chk("vec_no_overrun", out_overrun, 0);

        // Flush with nothing packed does nothing.
        host_flush = 1'b1;
        tick();
        host_flush = 1'b0;
        repeat (3) tick();
        chk("flush_empty_valid", out_valid, 0);
        chk("flush_empty_count", out_count, 3);

        // Ack and completion in the same cycle.
        send_bits(16'h1234, 16);
        chk("race_first", out_word, 16'h1234);
        vit_last_state = 6'h15;
        send_bits(16'h0F0F, 15);
        host_ack = 1'b1;
        tick();
        host_ack      = 1'b0;
        vit_bit       = 1'b1;
        vit_bit_valid = 1'b1;
        tick();
        vit_bit_valid = 1'b0;
        chk("race_valid", out_valid, 1);
        chk("race_word", out_word, 16'h8F0F);
        chk("race_state", out_last_state, 6'h15);
        chk("race_no_overrun", out_overrun, 0);
        pulse_ack();

        // Flush and bit in the same cycle: bit is packed first.
        send_bits(16'h0003, 2);
        host_flush = 1'b1;
        tick();
        host_flush    = 1'b0;
        vit_bit       = 1'b1;
        vit_bit_valid = 1'b1;
        tick();
        vit_bit_valid = 1'b0;
        chk("flushbit_valid", out_valid, 1);
        chk("flushbit_word", out_word, 16'h0007);
        chk("flushbit_count", out_count, 3);
        pulse_ack();

        // Reset mid-transfer discards FIFO and partial word.
        push_sym(8'h11);
        push_sym(8'h22);
        send_bits(16'h0007, 3);
        do_reset();
        chk("midrst_level", in_level, 0);
        chk("midrst_valid", vit_valid, 0);
        send_bits(16'h00FF, 16);
        chk("midrst_word", out_word, 16'h00FF);
        chk("midrst_count", out_count, 16);

        // Statistics.
        do_reset();
        vit_ready = 1'b1;
        for (int i = 0; i < 10; i++) push_sym(8'(i));
        vit_ready = 1'b0;
        send_bits(16'hFFFF, 16);
        pulse_ack();
        send_bits(16'h0000, 16);
        pulse_ack();
        send_bits(16'hABCD, 8);
`ifdef VIT_BRIDGE_STATS_EN
        chk("stat_sym", sym_count, 10);
        chk("stat_bit", bit_count, 40);
`else
        chk("stat_sym", sym_count, 0);
        chk("stat_bit", bit_count, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vit_dbg_bridge.md
# vit_dbg_bridge

Parametrised bridge between the debug-host register interface and the Viterbi decoder core. It replaces the single-symbol, single-result glue with three pieces: a soft-symbol input FIFO fed by host strobe edges, a valid/ready feed into the decoder, and a packer that assembles decoded bits into host-readable words with hold/ack semantics. It sits between the debug host instance and the `viterbi` instance in the board top level.

## Interface
- `SOFT_W`, 8: signed soft-symbol width.
- `DEPTH`, 16: input FIFO depth, power of two, ≥2.
- `STATE_W`, 6: decoder state width.
- `OUT_W`, 16: decoded bits per output word.

Ports:
- `clk` in 1: single clock for the whole block.
- `sys_rst` in 1: synchronous, active-high reset.
- `host_soft` in SOFT_W: signed symbol from host.
- `host_strobe` in 1: level from host; each rising edge pushes `host_soft` once.
- `host_flush` in 1: rising edge emits a partial word.
- `host_ack` in 1: rising edge releases the held output word.
- `vit_soft` out SOFT_W: FIFO head to decoder.
- `vit_valid` out 1: FIFO not empty.
- `vit_ready` in 1: decoder accepts head.
- `vit_bit` in 1, `vit_bit_valid` in 1: decoded bit stream.
- `vit_last_state` in STATE_W: decoder final state.
- `out_word` out OUT_W, `out_count` out $clog2(OUT_W+1), `out_last_state` out STATE_W, `out_valid` out 1: held result.
- `in_level` out $clog2(DEPTH+1): FIFO occupancy.
- `in_overflow` out 1, `out_overrun` out 1: sticky error flags.
- `sym_count` out 32, `bit_count` out 32: statistics.

## Operation
- Edge detect: `strobe_prev`, `flush_prev` and `ack_prev` register their inputs every cycle, including during reset. A level held high through reset release is therefore not an edge.
- Push: a strobe edge in cycle t registers `host_soft` and a push pulse. The write happens at the end of t+1.
- Push when full with no pop in the same cycle: the symbol is dropped and `in_overflow` sets.
- Push when full with a pop in the same cycle: the push is accepted.
- Pop: on `vit_valid & vit_ready`. The FIFO is first-word-fall-through, so `vit_soft` is the head whenever `vit_valid`=1.
- Read and write pointers wrap modulo DEPTH. `in_level` runs 0..DEPTH.
- Packer FSM has two states:
  - FILL: each `vit_bit_valid` writes `vit_bit` into bit index `cnt` (LSB first) and increments `cnt`. When `cnt` reaches OUT_W, or on a registered flush pulse with `cnt`>0, it latches `out_word` (unused high bits 0), `out_count` (= `cnt`) and `out_last_state`, sets `out_valid`, clears `cnt` and goes to HELD.
  - HELD: bits keep packing. A word that completes while still HELD is discarded and `out_overrun` sets. The held word is never overwritten.
  - A registered ack pulse clears `out_valid` and returns to FILL.
  - Ack pulse and a word completion in the same cycle: the new word loads, `out_valid` stays 1, `out_overrun` is not set.
- Flush pulse with `cnt`=0: no effect.
- Flush pulse and a bit in the same cycle: the bit is packed first, then the word is emitted.
- Reset: all outputs 0, FIFO empty, `cnt`=0, FSM in FILL, sticky flags cleared. Reset mid-transfer discards FIFO contents and any partial word.

## Timing
- Strobe edge at t → `vit_valid`=1 at t+2 when the FIFO was empty. `in_level` updates at t+2.
- Last bit of a word at t → `out_valid`=1 at t+1.
- Flush edge at t → word visible at t+2.
- Ack edge at t → `out_valid`=0 at t+2.
- Pop at t → the new head is visible at t+1.
- Sticky flags set one cycle after the offending event.

## Configuration
- `VIT_BRIDGE_STATS_EN` defined:
  - `sym_count` increments on every accepted push.
  - `bit_count` increments on every `vit_bit_valid`.
  - Both saturate at 2^32−1 and clear on reset.
- Undefined: both ports remain present and are tied to 0, and no counter logic is built.

## Structure
- Package `vit_bridge_pkg` holds:
  - the default `STATE_W` and `SOFT_W` constants;
  - `typedef logic signed [SOFT_W-1:0] soft_t`;
  - the packer state enum `{FILL, HELD}`.
- Sub-module `vit_sym_fifo` holds the synchronous FWFT FIFO with `DEPTH`, push/pop, full/empty and level. The top of the block contains edge detection, the packer, flags and counters.

## Test plan
- Reset with `host_strobe` held high, then release → no push; `in_level`=0, `vit_valid`=0.
- 3 strobe edges carrying −5, 0, 127 with `vit_ready`=0 → `in_level`=3. Then `vit_ready`=1 → `vit_soft` sequence −5, 0, 127, then `vit_valid`=0.
- 17 pushes with DEPTH=16 and no pops → `in_level`=16, `in_overflow`=1, first 16 values preserved. A push coinciding with a pop at full is accepted.
- 16 bits alternating 1,0 → `out_word`=16'h5555, `out_count`=16, `out_valid`=1 one cycle after the last bit. A further 16 bits with no ack → `out_overrun`=1 and `out_word` unchanged.
- 5 bits of 1 then a flush edge → `out_word`=16'h001F, `out_count`=5. Ack edge → `out_valid`=0 two cycles later. Flush with `cnt`=0 → no change.
- With `VIT_BRIDGE_STATS_EN` defined: 10 pushes and 40 bits → `sym_count`=10, `bit_count`=40. Without the macro → both read 0.
